dpram_fifo_ctrl_2048x8: RTL and testbench



---
 rtl/dpram_fifo_ctrl_2048x8.sv | 133 +++++++++++++
 tb/tb_dpram_fifo_ctrl_2048x8.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl_2048x8.sv
// FIFO controller for an external 2048 x 8 dual-port RAM with a registered read port.
// It drives the RAM ports, tracks occupancy and raises status and sticky error flags.
module dpram_fifo_ctrl_2048x8 #(
    parameter int DEPTH_LOG2 = 11,
    parameter int WIDTH      = 8,
    parameter int AF_THRESH  = 2040,
    parameter int AE_THRESH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [0:WIDTH-1]      push_data,
    input  logic                  pop,
    output logic [0:WIDTH-1]      pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [0:DEPTH_LOG2]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic                  ram_wen,
    output logic [0:DEPTH_LOG2-1] ram_waddr,
    output logic [0:WIDTH-1]      ram_data_in,
    output logic                  ram_ren,
    output logic [0:DEPTH_LOG2-1] ram_raddr,
    input  logic [0:WIDTH-1]      ram_data_out
);

    localparam logic [0:DEPTH_LOG2]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [0:DEPTH_LOG2]   AF_C    = (DEPTH_LOG2+1)'(AF_THRESH);
    localparam logic [0:DEPTH_LOG2]   AE_C    = (DEPTH_LOG2+1)'(AE_THRESH);
    localparam logic [0:DEPTH_LOG2-1] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [0:DEPTH_LOG2]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [0:DEPTH_LOG2-1] wptr_r;
    logic [0:DEPTH_LOG2-1] rptr_r;
    logic [0:DEPTH_LOG2]   count_r;
    logic [0:DEPTH_LOG2]   count_nxt_s;
    logic                  pop_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_acc_s;
    logic                  pop_acc_s;

    // Flags are decoded from the registered count only.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {(DEPTH_LOG2+1){1'b0}});
    end

    // Accept decisions; a full FIFO with push+pop takes only the pop, an empty one only the push.
    always_comb begin
        push_acc_s = push & ~full_s & ~flush;
        pop_acc_s  = pop & ~empty_s & ~flush;
    end

    // Occupancy next-state.
    always_comb begin
        count_nxt_s = count_r;
        if (push_acc_s && !pop_acc_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_acc_s && !push_acc_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, count and read-data qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r      <= {DEPTH_LOG2{1'b0}};
            rptr_r      <= {DEPTH_LOG2{1'b0}};
            count_r     <= {(DEPTH_LOG2+1){1'b0}};
            pop_valid_r <= 1'b0;
        end else if (flush) begin
            wptr_r      <= {DEPTH_LOG2{1'b0}};
            rptr_r      <= {DEPTH_LOG2{1'b0}};
            count_r     <= {(DEPTH_LOG2+1){1'b0}};
            pop_valid_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_acc_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            pop_valid_r <= pop_acc_s;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && full_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (pop && empty_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign ram_wen      = push_acc_s;
    assign ram_waddr    = wptr_r;
    assign ram_data_in  = push_data;
    assign ram_ren      = pop_acc_s;
    assign ram_raddr    = rptr_r;
    assign pop_data     = ram_data_out;
    assign pop_valid    = pop_valid_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AF_C);
    assign almost_empty = (count_r <= AE_C);
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_dpram_fifo_ctrl_2048x8.sv
// Bench for dpram_fifo_ctrl_2048x8: attaches a RAM model and checks every cycle
// against a queue-based reference of FIFO behaviour.
module tb_dpram_fifo_ctrl_2048x8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [0:7]  push_data = 8'h00;
    logic [0:7]  pop_data, ram_data_in, ram_data_out;
    logic        pop_valid, full, empty, almost_full, almost_empty;
    logic [0:11] count;
    logic        overflow, underflow, ram_wen, ram_ren;
    logic [0:10] ram_waddr, ram_raddr;

    logic [0:7]  mem [0:2047];
    logic [0:7]  ram_q;

    int          n_checks = 0;
    int          n_fail = 0;

    // reference model state
    logic [7:0]  q[$];
    int          wa = 0, ra = 0;
    bit          m_pv = 0, m_ovf = 0, m_unf = 0, pd_known = 0;
    logic [7:0]  m_pd = 8'h00;

    dpram_fifo_ctrl_2048x8 dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_data_in(ram_data_in),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // 2048 x 8 RAM with enable-gated registered read
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_data_in;
        if (ram_ren) ram_q <= mem[ram_raddr];
    end
    assign ram_data_out = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 2048));
        chk("almost_full", 32'(almost_full), 32'(n >= 2040));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 8));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        if (pd_known) chk("pop_data", 32'(pop_data), 32'(m_pd));
    endtask

    // One clock cycle: drive at negedge, check before posedge, advance model after it.
    task automatic cyc(input logic p, input logic [7:0] d, input logic po,
                       input logic fl, input logic ce);
        bit pacc, racc;
        int n;
        push = p; push_data = d; pop = po; flush = fl; clr_err = ce;
        #1;
        n    = q.size();
        pacc = p && !fl && (n < 2048);
        racc = po && !fl && (n > 0);
        chk_status();
        chk("ram_wen", 32'(ram_wen), 32'(pacc));
        chk("ram_ren", 32'(ram_ren), 32'(racc));
        chk("ram_waddr", 32'(ram_waddr), 32'(wa));
        chk("ram_raddr", 32'(ram_raddr), 32'(ra));
        if (pacc) chk("ram_data_in", 32'(ram_data_in), 32'(d));
        @(posedge clk);
        if (p && n == 2048) m_ovf = 1; else if (ce) m_ovf = 0;
        if (po && n == 0) m_unf = 1; else if (ce) m_unf = 0;
        if (fl) begin
            q.delete(); wa = 0; ra = 0;
        end else begin
            if (racc) begin
                m_pd = q.pop_front(); pd_known = 1; ra = (ra + 1) % 2048;
            end
            if (pacc) begin
                q.push_back(d); wa = (wa + 1) % 2048;
            end
        end
        m_pv = racc;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete(); wa = 0; ra = 0; m_pv = 0; m_ovf = 0; m_unf = 0; pd_known = 0;
    endtask

    task automatic check_reset_outputs();
        chk_status();
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_ram_ren", 32'(ram_ren), 32'd0);
        chk("rst_waddr", 32'(ram_waddr), 32'd0);
        chk("rst_raddr", 32'(ram_raddr), 32'd0);
    endtask

    initial begin
        // power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1; check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // idle, then pop while empty, then clear with a colliding new error
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 256-word sequential pass
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 257; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // fill to full with address-derived data, then one extra push
        for (int i = 0; i < 2048; i++) cyc(1'b1, 8'(wa), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

        // push+pop at full, refill, then stream 2048 with concurrent random pushes
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2048; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // flush with count 5 and simultaneous push/pop
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // randomized mixed traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 8'($urandom),
                1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 999) < 5),
                1'($urandom_range(0, 99) < 3));
        end

        // mid-stream reset with count 100 and a read in flight
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 101; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd100);
        chk("pre_rst_pop_valid", 32'(pop_valid), 32'd1);
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("a5_returned", 32'(pop_data), 32'h0000_00A5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
